// File: rtl/gcd_job_sequencer.sv
// Front-end sequencer for the GCD core: accepts operand pairs, clears and loads the core,
// waits for done (with timeout and cycle count) and returns the result over valid/ready.
module gcd_job_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned TMO_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_rst,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [15:0]      out_cycles
);

  localparam int unsigned TW = $clog2(TMO_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_START = 3'd2,
    S_LOADA = 3'd3,
    S_LOADB = 3'd4,
    S_WAIT  = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [TW-1:0]     wait_cnt, wait_d;
  logic [15:0]       cyc_cnt, cyc_d;
  logic [WIDTH-1:0]  gcd_d;
  logic              err_d;
  logic [15:0]       cycles_d;
  logic              clr_q;
  logic              in_ready_d, clr_d, start_d, valid_d;
  logic [WIDTH-1:0]  data_d;
  logic [15:0]       cyc_inc;

  // Saturating increment of the job cycle counter; never wraps.
  assign cyc_inc = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;

  assign core_rst = rst | clr_q;

  // Next-state and next-value logic for every register.
  always_comb begin
    state_next = state;
    a_d        = a_q;
    b_d        = b_q;
    wait_d     = wait_cnt;
    cyc_d      = cyc_cnt;
    gcd_d      = out_gcd;
    err_d      = out_err;
    cycles_d   = out_cycles;

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d = in_a;
          b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            gcd_d      = in_a | in_b;
            err_d      = 1'b0;
            cycles_d   = 16'd0;
            state_next = S_RESP;
          end else begin
            state_next = S_CLR;
          end
        end
      end
      S_CLR: begin
        cyc_d      = 16'd0;
        state_next = S_START;
      end
      S_START: begin
        cyc_d      = cyc_inc;
        state_next = S_LOADA;
      end
      S_LOADA: begin
        cyc_d      = cyc_inc;
        state_next = S_LOADB;
      end
      S_LOADB: begin
        cyc_d      = cyc_inc;
        wait_d     = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        cyc_d  = cyc_inc;
        wait_d = wait_cnt + TW'(1);
        // Done in the final allowed cycle still wins over the timeout.
        if (core_done) begin
          gcd_d      = core_result;
          err_d      = 1'b0;
          cycles_d   = cyc_inc;
          state_next = S_RESP;
        end else if (wait_cnt == TW'(TMO_CYCLES - 1)) begin
          gcd_d      = '0;
          err_d      = 1'b1;
          cycles_d   = cyc_inc;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    in_ready_d = (state_next == S_IDLE);
    clr_d      = (state_next == S_CLR);
    start_d    = (state_next == S_START);
    valid_d    = (state_next == S_RESP);
    case (state_next)
      S_START, S_LOADA: data_d = a_d;
      S_LOADB, S_WAIT:  data_d = b_d;
      default:          data_d = '0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      wait_cnt   <= '0;
      cyc_cnt    <= 16'd0;
      in_ready   <= 1'b0;
      clr_q      <= 1'b0;
      core_start <= 1'b0;
      core_data  <= '0;
      out_valid  <= 1'b0;
      out_gcd    <= '0;
      out_err    <= 1'b0;
      out_cycles <= 16'd0;
    end else begin
      state      <= state_next;
      a_q        <= a_d;
      b_q        <= b_d;
      wait_cnt   <= wait_d;
      cyc_cnt    <= cyc_d;
      in_ready   <= in_ready_d;
      clr_q      <= clr_d;
      core_start <= start_d;
      core_data  <= data_d;
      out_valid  <= valid_d;
      out_gcd    <= gcd_d;
      out_err    <= err_d;
      out_cycles <= cycles_d;
    end
  end

endmodule
